// File: rtl/aec_param.sv
// Streaming hex-expression calculator: collects characters into a token
// buffer, converts infix to postfix with an operator stack, then evaluates
// the postfix sequence on an operand stack. All arithmetic is unsigned
// modulo 2^DW.
`timescale 1ns/1ps
module aec_param #(
  parameter int DW     = 16,
  parameter int MAXLEN = 32,
  parameter int SDEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ascii_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          valid,
  output logic [DW-1:0] result,
  output logic          err
);

  localparam int CW = $clog2(MAXLEN);
  localparam int SW = $clog2(SDEPTH);

  typedef enum logic [2:0] {LOAD, CONVERT, DRAIN, EVAL, DONE} state_t;

  localparam logic [2:0] T_NUM = 3'd0;
  localparam logic [2:0] T_ADD = 3'd1;
  localparam logic [2:0] T_SUB = 3'd2;
  localparam logic [2:0] T_MUL = 3'd3;
  localparam logic [2:0] T_LP  = 3'd4;
  localparam logic [2:0] T_RP  = 3'd5;

  localparam logic [CW:0] TOK_MAX = MAXLEN[CW:0];
  localparam logic [CW:0] T_ONE   = 1;
  localparam logic [SW:0] STK_MAX = SDEPTH[SW:0];
  localparam logic [SW:0] S_ONE   = 1;
  localparam logic [SW:0] S_TWO   = 2;

  function automatic logic [1:0] prec(input logic [2:0] op);
    case (op)
      T_MUL:        return 2'd2;
      T_ADD, T_SUB: return 2'd1;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] alu(input logic [2:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      T_ADD:   return a + b;
      T_SUB:   return a - b;
      T_MUL:   return a * b;
      default: return '0;
    endcase
  endfunction

  state_t state, state_nx;

  logic [CW:0] ntok, tidx, npf, pidx;
  logic [SW:0] osp, esp;
  logic        in_num, err_flag;

  logic [2:0]    tok_op [MAXLEN];
  logic [DW-1:0] tok_val[MAXLEN];
  logic [2:0]    pf_op  [MAXLEN];
  logic [DW-1:0] pf_val [MAXLEN];
  logic [2:0]    ostk   [SDEPTH];
  logic [DW-1:0] estk   [SDEPTH];

  logic       is_dig, is_op, is_eq;
  logic [3:0] dig;
  logic [2:0] opc;

  logic [CW-1:0] tix, pix, lst;
  logic [SW-1:0] otop_ix, etop_ix, enxt_ix;
  logic [2:0]    cur_op, otop, pf_cur;

  logic fail, ok, ld_bad, ld_ovf, ld_new, ld_upd;
  logic emit_cur, push_cur, pop_emit, pop_drop, adv, ev_push, ev_op;

  assign tix     = tidx[CW-1:0];
  assign pix     = pidx[CW-1:0];
  assign lst     = CW'(ntok - T_ONE);
  assign otop_ix = SW'(osp - S_ONE);
  assign etop_ix = SW'(esp - S_ONE);
  assign enxt_ix = SW'(esp - S_TWO);
  assign cur_op  = tok_op[tix];
  assign otop    = ostk[otop_ix];
  assign pf_cur  = pf_op[pix];

  assign in_ready = (state == LOAD);
  assign valid    = (state == DONE);

  // Classify the incoming character.
  always_comb begin
    is_dig = 1'b0;
    is_op  = 1'b0;
    is_eq  = 1'b0;
    dig    = 4'd0;
    opc    = T_NUM;
    if (ascii_in >= 8'd48 && ascii_in <= 8'd57) begin
      is_dig = 1'b1;
      dig    = ascii_in[3:0];
    end else if (ascii_in >= 8'd97 && ascii_in <= 8'd102) begin
      is_dig = 1'b1;
      dig    = 4'(ascii_in - 8'd87);
    end
    case (ascii_in)
      8'd43:   begin is_op = 1'b1; opc = T_ADD; end
      8'd45:   begin is_op = 1'b1; opc = T_SUB; end
      8'd42:   begin is_op = 1'b1; opc = T_MUL; end
      8'd40:   begin is_op = 1'b1; opc = T_LP;  end
      8'd41:   begin is_op = 1'b1; opc = T_RP;  end
      8'd61:   is_eq = 1'b1;
      default: ;
    endcase
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nx = state;
    fail = 1'b0; ok = 1'b0;
    ld_bad = 1'b0; ld_ovf = 1'b0; ld_new = 1'b0; ld_upd = 1'b0;
    emit_cur = 1'b0; push_cur = 1'b0; pop_emit = 1'b0; pop_drop = 1'b0;
    adv = 1'b0; ev_push = 1'b0; ev_op = 1'b0;
    case (state)
      LOAD: if (in_valid) begin
        if (is_eq) begin
          if (err_flag || ntok == '0) fail = 1'b1;
          else                        state_nx = CONVERT;
        end else if (!err_flag) begin
          if (!(is_dig || is_op))   ld_bad = 1'b1;
          else if (is_dig && in_num) ld_upd = 1'b1;
          else if (ntok == TOK_MAX) ld_ovf = 1'b1;
          else                       ld_new = 1'b1;
        end
      end
      CONVERT: begin
        if (tidx == ntok) state_nx = DRAIN;
        else begin
          case (cur_op)
            T_NUM: begin emit_cur = 1'b1; adv = 1'b1; end
            T_LP: begin
              if (osp == STK_MAX) fail = 1'b1;
              else begin push_cur = 1'b1; adv = 1'b1; end
            end
            T_RP: begin
              if (osp == '0)          fail = 1'b1;
              else if (otop == T_LP) begin pop_drop = 1'b1; adv = 1'b1; end
              else                    pop_emit = 1'b1;
            end
            default: begin
              // Operators of higher or equal precedence leave first,
              // which also gives left associativity.
              if (osp != '0 && otop != T_LP && prec(otop) >= prec(cur_op))
                pop_emit = 1'b1;
              else if (osp == STK_MAX) fail = 1'b1;
              else begin push_cur = 1'b1; adv = 1'b1; end
            end
          endcase
        end
      end
      DRAIN: begin
        if (osp == '0)         state_nx = EVAL;
        else if (otop == T_LP) fail = 1'b1;
        else                   pop_emit = 1'b1;
      end
      EVAL: begin
        if (pidx == npf) begin
          if (esp != S_ONE) fail = 1'b1;
          else begin ok = 1'b1; state_nx = DONE; end
        end else if (pf_cur == T_NUM) begin
          if (esp == STK_MAX) fail = 1'b1;
          else                ev_push = 1'b1;
        end else begin
          if (esp < S_TWO) fail = 1'b1;
          else             ev_op = 1'b1;
        end
      end
      DONE:    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
    if (fail) state_nx = DONE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Pointers and flags; everything returns to empty when DONE hands back to LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ntok <= '0; tidx <= '0; npf <= '0; pidx <= '0;
      osp <= '0; esp <= '0; in_num <= 1'b0; err_flag <= 1'b0;
    end else if (state == DONE) begin
      ntok <= '0; tidx <= '0; npf <= '0; pidx <= '0;
      osp <= '0; esp <= '0; in_num <= 1'b0; err_flag <= 1'b0;
    end else begin
      if (ld_bad || ld_ovf) err_flag <= 1'b1;
      if (state == LOAD && in_valid && !is_dig) in_num <= 1'b0;
      else if (ld_new && is_dig)                in_num <= 1'b1;
      if (ld_new) ntok <= ntok + T_ONE;
      if (adv) tidx <= tidx + T_ONE;
      if (emit_cur || pop_emit) npf <= npf + T_ONE;
      if (push_cur)                 osp <= osp + S_ONE;
      else if (pop_emit || pop_drop) osp <= osp - S_ONE;
      if (ev_push)    esp <= esp + S_ONE;
      else if (ev_op) esp <= esp - S_ONE;
      if (ev_push || ev_op) pidx <= pidx + T_ONE;
    end
  end

  // Result register, loaded when the expression completes or is rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      err    <= 1'b0;
    end else if (fail) begin
      result <= '0;
      err    <= 1'b1;
    end else if (ok) begin
      result <= estk[0];
      err    <= 1'b0;
    end
  end

  // Token, postfix and stack storage; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (ld_new) begin
      tok_op[ntok[CW-1:0]]  <= is_dig ? T_NUM : opc;
      tok_val[ntok[CW-1:0]] <= is_dig ? DW'(dig) : '0;
    end
    if (ld_upd) tok_val[lst] <= (tok_val[lst] << 4) | DW'(dig);
    if (emit_cur) begin
      pf_op[npf[CW-1:0]]  <= T_NUM;
      pf_val[npf[CW-1:0]] <= tok_val[tix];
    end
    if (pop_emit) begin
      pf_op[npf[CW-1:0]]  <= otop;
      pf_val[npf[CW-1:0]] <= '0;
    end
    if (push_cur) ostk[osp[SW-1:0]] <= cur_op;
    if (ev_push)  estk[esp[SW-1:0]] <= pf_val[pix];
    if (ev_op)    estk[enxt_ix] <= alu(pf_cur, estk[enxt_ix], estk[etop_ix]);
  end

endmodule
